// File: rtl/data_memory_arbiter.sv
// Two-port data-memory arbiter (LSU = port 0, loader DMA = port 1) with bounded ownership lock.
// Optional macro DATA_ARB_ROUND_ROBIN_EN: alternate winners on ties instead of port-0 priority.
module data_memory_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MAX_LOCK   = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  p0_req,
  input  logic                  p1_req,
  input  logic                  p0_we,
  input  logic                  p1_we,
  input  logic                  p0_lock,
  input  logic                  p1_lock,
  input  logic [2:0]            p0_byte_enable,
  input  logic [2:0]            p1_byte_enable,
  input  logic [ADDR_WIDTH-1:0] p0_address,
  input  logic [ADDR_WIDTH-1:0] p1_address,
  input  logic [DATA_WIDTH-1:0] p0_write_data,
  input  logic [DATA_WIDTH-1:0] p1_write_data,
  output logic                  p0_gnt,
  output logic                  p1_gnt,
  output logic                  p0_rvalid,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic [2:0]            mem_byte_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_data_fetched
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  localparam logic [8:0] MAX_LOCK_W = 9'(MAX_LOCK);

  state_e     state_q, state_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic       last_winner_q, last_winner_d;
  logic       forced_q, forced_d;
  logic       resp_pending_q, resp_pending_d;
  logic       resp_port_q, resp_port_d;

  logic       gnt0, gnt1, any_gnt, sel_we, sel_lock;
  logic [8:0] next_cnt;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (p0_req && p1_req) begin
`ifdef DATA_ARB_ROUND_ROBIN_EN
          gnt0 = last_winner_q;
          gnt1 = ~last_winner_q;
`else
          // Port 0 normally wins, except right after port 0 was forced off its lock.
          gnt1 = forced_q & ~last_winner_q;
          gnt0 = ~gnt1;
`endif
        end else begin
          gnt0 = p0_req;
          gnt1 = p1_req;
        end
      end
      OWN0:    gnt0 = p0_req;
      OWN1:    gnt1 = p1_req;
      default: ;
    endcase
    if (!reset_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end

    any_gnt  = gnt0 | gnt1;
    sel_we   = gnt1 ? p1_we   : p0_we;
    sel_lock = gnt1 ? p1_lock : p0_lock;

    p0_gnt          = gnt0;
    p1_gnt          = gnt1;
    mem_read_en     = any_gnt & ~sel_we;
    mem_write_en    = any_gnt & sel_we;
    mem_byte_enable = '0;
    mem_address     = '0;
    mem_write_data  = '0;
    if (any_gnt) begin
      mem_byte_enable = gnt1 ? p1_byte_enable : p0_byte_enable;
      mem_address     = gnt1 ? p1_address     : p0_address;
      mem_write_data  = gnt1 ? p1_write_data  : p0_write_data;
    end
  end

  always_comb begin
    state_d        = state_q;
    lock_cnt_d     = lock_cnt_q;
    last_winner_d  = last_winner_q;
    forced_d       = 1'b0;
    resp_pending_d = any_gnt & ~sel_we;
    resp_port_d    = any_gnt ? gnt1 : resp_port_q;
    next_cnt       = (state_q == IDLE) ? 9'd1 : {1'b0, lock_cnt_q} + 9'd1;

    if (any_gnt) begin
      last_winner_d = gnt1;
      if (sel_lock && (next_cnt < MAX_LOCK_W)) begin
        state_d    = gnt1 ? OWN1 : OWN0;
        lock_cnt_d = next_cnt[7:0];
      end else begin
        // Either an unlocked access or the access that exhausts the lock budget.
        state_d    = IDLE;
        lock_cnt_d = '0;
        forced_d   = sel_lock;
      end
    end else begin
      state_d    = IDLE;
      lock_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      lock_cnt_q     <= '0;
      last_winner_q  <= 1'b1;
      forced_q       <= 1'b0;
      resp_pending_q <= 1'b0;
      resp_port_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      lock_cnt_q     <= lock_cnt_d;
      last_winner_q  <= last_winner_d;
      forced_q       <= forced_d;
      resp_pending_q <= resp_pending_d;
      resp_port_q    <= resp_port_d;
    end
  end

  always_comb begin
    p0_rvalid = resp_pending_q & ~resp_port_q;
    p1_rvalid = resp_pending_q & resp_port_q;
    p0_rdata  = p0_rvalid ? mem_data_fetched : '0;
    p1_rdata  = p1_rvalid ? mem_data_fetched : '0;
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Randomized + directed bench for data_memory_arbiter with a scoreboard of expected read returns.
module tb_data_memory_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int ML = 15;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          p0_req, p1_req, p0_we, p1_we, p0_lock, p1_lock;
  logic [2:0]    p0_byte_enable, p1_byte_enable;
  logic [AW-1:0] p0_address, p1_address;
  logic [DW-1:0] p0_write_data, p1_write_data;
  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          mem_read_en, mem_write_en;
  logic [2:0]    mem_byte_enable;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic [DW-1:0] mem_data_fetched;

  data_memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(ML)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
    .p0_lock(p0_lock), .p1_lock(p1_lock),
    .p0_byte_enable(p0_byte_enable), .p1_byte_enable(p1_byte_enable),
    .p0_address(p0_address), .p1_address(p1_address),
    .p0_write_data(p0_write_data), .p1_write_data(p1_write_data),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_data_fetched(mem_data_fetched)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] init_val(input int i);
    if (i == 0) return 64'h1122334455667788;
    return {32'hA5A50000 | i, 32'h0F0F0000 + i * 17};
  endfunction

  // Behavioural data memory: one-cycle read latency, garbage on the bus when not reading.
  logic          preload = 1'b0;
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
    end else if (mem_write_en) begin
      mem[mem_address[6:3]] <= mem_write_data;
    end
    if (mem_read_en) mem_data_fetched <= mem[mem_address[6:3]];
    else             mem_data_fetched <= {$urandom, $urandom};
  end

  typedef struct {
    bit            req, we, lock;
    logic [2:0]    be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } txn_t;

  typedef struct {
    int            due;
    bit            port;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] ref_mem [16];
  int            own = -1;
  int            run = 0;
  int            lastw = 1;
  bit            starve1 = 1'b0;
  bit            release_pending = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    own = -1; run = 0; lastw = 1; starve1 = 1'b0;
    q.delete();
  endtask

  function automatic txn_t rd(input logic [AW-1:0] a, input bit lk);
    txn_t t = '{default: '0};
    t.req = 1'b1; t.lock = lk; t.addr = a; t.be = 3'b011;
    return t;
  endfunction

  // Drive one cycle, check the combinational grant/memory side against the model, queue read returns.
  task automatic run_cycle(input txn_t t0, input txn_t t1, output bit g0, output bit g1);
    int   win;
    txn_t w;
    bit   s1n;
    @(negedge clk);
    if (release_pending) begin reset_n = 1'b1; release_pending = 1'b0; end
    p0_req = t0.req; p0_we = t0.we; p0_lock = t0.lock; p0_byte_enable = t0.be;
    p0_address = t0.addr; p0_write_data = t0.wd;
    p1_req = t1.req; p1_we = t1.we; p1_lock = t1.lock; p1_byte_enable = t1.be;
    p1_address = t1.addr; p1_write_data = t1.wd;
    #1;
    win = -1;
    if (!reset_n) win = -1;
    else if (own == 0) win = t0.req ? 0 : -1;
    else if (own == 1) win = t1.req ? 1 : -1;
    else if (t0.req && t1.req) begin
`ifdef DATA_ARB_ROUND_ROBIN_EN
      win = 1 - lastw;
`else
      win = starve1 ? 1 : 0;
`endif
    end else if (t0.req) win = 0;
    else if (t1.req) win = 1;
    w = (win == 1) ? t1 : t0;

    chk("gnt", {62'd0, p0_gnt, p1_gnt}, {62'd0, win == 0, win == 1});
    chk("mem_en", {62'd0, mem_read_en, mem_write_en},
        {62'd0, win >= 0 && !w.we, win >= 0 && w.we});
    chk("mem_address", 64'(mem_address), (win >= 0) ? 64'(w.addr) : 64'd0);
    chk("mem_byte_enable", 64'(mem_byte_enable), (win >= 0) ? 64'(w.be) : 64'd0);
    chk("mem_write_data", mem_write_data, (win >= 0) ? w.wd : 64'd0);

    if (win >= 0 && !w.we) q.push_back('{cyc + 1, win[0], ref_mem[w.addr[6:3]]});
    if (win >= 0 && w.we) ref_mem[w.addr[6:3]] = w.wd;

    s1n = 1'b0;
    if (win >= 0) begin
      lastw = win;
      if (w.lock) begin
        run = (own < 0) ? 1 : run + 1;
        if (run >= ML) begin own = -1; run = 0; s1n = (win == 0); end
        else own = win;
      end else begin own = -1; run = 0; end
    end else begin own = -1; run = 0; end
    starve1 = s1n;
    g0 = p0_gnt;
    g1 = p1_gnt;
  endtask

  // Monitor: every cycle, rvalid/rdata must match the head of the scoreboard (or be idle/zero).
  initial begin
    exp_t e;
    bit   v0, v1;
    logic [DW-1:0] d;
    forever begin
      @(posedge clk);
      #1;
      v0 = 1'b0; v1 = 1'b0; d = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        v0 = ~e.port; v1 = e.port; d = e.data;
      end
      chk("rvalid", {62'd0, p0_rvalid, p1_rvalid}, {62'd0, v0, v1});
      chk("p0_rdata", p0_rdata, v0 ? d : 64'd0);
      chk("p1_rdata", p1_rdata, v1 ? d : 64'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t idle, a0, a1, pend0, pend1;
    bit   g0, g1;
    logic [7:0] seq;
    int   cnt, lockp;
    bit   p1_done;

    idle = '{default: '0};
    p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0; p0_lock = 0; p1_lock = 0;
    p0_byte_enable = '0; p1_byte_enable = '0; p0_address = '0; p1_address = '0;
    p0_write_data = '0; p1_write_data = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    preload = 1'b1;
    model_reset();

    // Reset: requests present but nothing may be granted.
    run_cycle(rd(32'h0000_1000, 1'b0), rd(32'h0000_1008, 1'b0), g0, g1);
    run_cycle(idle, idle, g0, g1);
    preload = 1'b0;
    release_pending = 1'b1;

    // Single p0 read with known memory content.
    run_cycle(rd(32'h0000_1000, 1'b0), idle, g0, g1);
    chk("t1_gnt", {63'd0, g0}, 64'd1);
    run_cycle(idle, idle, g0, g1);
    chk("t1_rvalid", {63'd0, p0_rvalid}, 64'd1);
    chk("t1_rdata", p0_rdata, 64'h1122334455667788);

    // p1 write.
    a1 = '{req: 1'b1, we: 1'b1, lock: 1'b0, be: 3'b010, addr: 32'h0000_2008, wd: 64'hDEADBEEF};
    run_cycle(idle, a1, g0, g1);
    chk("t3_write", {61'd0, mem_write_en, mem_byte_enable}, {61'd0, 1'b1, 3'b010});
    chk("t3_addr", 64'(mem_address), 64'h0000_2008);
    run_cycle(idle, idle, g0, g1);

    // Both read, held four cycles.
    seq = '0;
    for (int k = 0; k < 4; k++) begin
      run_cycle(rd(32'h0000_1008, 1'b0), rd(32'h0000_1010, 1'b0), g0, g1);
      seq = {seq[5:0], g0, g1};
    end
`ifdef DATA_ARB_ROUND_ROBIN_EN
    chk("t2_tie_seq", 64'(seq), 64'b10_01_10_01);
`else
    chk("t2_tie_seq", 64'(seq), 64'b10_10_10_10);
`endif

    // p1 holds the lock for three accesses while p0 waits.
    a1 = '{req: 1'b1, we: 1'b1, lock: 1'b1, be: 3'b111, addr: 32'h0000_2010, wd: 64'h5555_AAAA_0000_1234};
    run_cycle(idle, a1, g0, g1);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) a1.lock = 1'b0;
      run_cycle(rd(32'h0000_1000, 1'b0), a1, g0, g1);
      cnt += int'(g0);
    end
    chk("t4_p0_blocked", 64'(cnt), 64'd0);
    run_cycle(rd(32'h0000_1000, 1'b0), idle, g0, g1);
    chk("t4_p0_after", {63'd0, g0}, 64'd1);

    // p0 locks for 20 cycles; forced release after MAX_LOCK grants hands over to p1.
    cnt = 0;
    p1_done = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      a1 = (k >= 2 && !p1_done) ? rd(32'h0000_1020, 1'b0) : idle;
      run_cycle(rd(32'h0000_1018, 1'b1), a1, g0, g1);
      if (g1) p1_done = 1'b1;
      if (k <= ML && g0 && !g1) cnt++;
      if (k == ML + 1) chk("t5_handover", {62'd0, g0, g1}, 64'b01);
    end
    chk("t5_p0_streak", 64'(cnt), 64'(ML));

    // Reset in the cycle after a granted read: the read return is dropped.
    run_cycle(rd(32'h0000_1000, 1'b0), idle, g0, g1);
    #2;
    reset_n = 1'b0;
    model_reset();
    run_cycle(rd(32'h0000_1000, 1'b0), idle, g0, g1);
    chk("t6_gnt_in_reset", {63'd0, g0}, 64'd0);
    release_pending = 1'b1;
    run_cycle(rd(32'h0000_1000, 1'b0), rd(32'h0000_1008, 1'b0), g0, g1);
    chk("t6_first_tie", {62'd0, g0, g1}, 64'b10);

    // Randomized traffic; requests held stable until granted.
    pend0 = idle;
    pend1 = idle;
    lockp = 10;
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) lockp = (n % 1000 == 0) ? 10 : 90;
      if (!pend0.req && $urandom_range(0, 99) < 60) begin
        pend0 = '{req: 1'b1, we: ($urandom_range(0, 2) == 0), lock: ($urandom_range(0, 99) < lockp),
                  be: 3'($urandom), addr: 32'h0000_3000 | (32'($urandom_range(0, 15)) << 3),
                  wd: {$urandom, $urandom}};
      end
      if (!pend1.req && $urandom_range(0, 99) < 60) begin
        pend1 = '{req: 1'b1, we: ($urandom_range(0, 2) == 0), lock: ($urandom_range(0, 99) < lockp),
                  be: 3'($urandom), addr: 32'h0000_3000 | (32'($urandom_range(0, 15)) << 3),
                  wd: {$urandom, $urandom}};
      end
      run_cycle(pend0, pend1, g0, g1);
      if (g0) pend0 = idle;
      if (g1) pend1 = idle;
    end

    run_cycle(idle, idle, g0, g1);
    run_cycle(idle, idle, g0, g1);
    chk("drain", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
Two-port arbiter that shares the single data-memory interface between the core load/store unit (port 0) and the program/data loader DMA (port 1). It grants at most one access per cycle and drives the memory-interface request signals combinationally from the winning port. It routes the one-cycle-latency read data back to the issuing port with a registered valid pulse. It supports a bounded ownership lock, so a requester can make back-to-back accesses without interleaving.

Parameters:
ADDR_WIDTH, 32, address width of both ports and of the memory side
DATA_WIDTH, 64, data width of both ports and of the memory side
MAX_LOCK, 15, maximum consecutive granted cycles under lock before ownership is forcibly released (1..255)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
p0_req, p1_req  in  1  access request
p0_we, p1_we  in  1  1=write, 0=read
p0_lock, p1_lock  in  1  keep ownership after this access
p0_byte_enable, p1_byte_enable  in  3  size/sign code, passed unchanged to memory
p0_address, p1_address  in  ADDR_WIDTH  byte address
p0_write_data, p1_write_data  in  DATA_WIDTH  store data
p0_gnt, p1_gnt  out  1  combinational; access accepted this cycle
p0_rvalid, p1_rvalid  out  1  registered; read data valid this cycle
p0_rdata, p1_rdata  out  DATA_WIDTH  read data; zero when the matching rvalid is 0
mem_read_en, mem_write_en  out  1  to data memory interface
mem_byte_enable  out  3  selected byte_enable
mem_address  out  ADDR_WIDTH  selected address
mem_write_data  out  DATA_WIDTH  selected write data
mem_data_fetched  in  DATA_WIDTH  memory read data, valid 1 cycle after mem_read_en

Behaviour:
- States:
  - IDLE: no owner.
  - OWN0: port 0 holds the lock.
  - OWN1: port 1 holds the lock.
- Reset (async, reset_n=0):
  - State goes to IDLE; lock counter = 0; last_winner = 1, so port 0 wins the first tie.
  - Response registers clear: resp_port = 0, resp_pending = 0.
  - All gnt, rvalid and mem_* enables are 0; all data outputs are 0.
- Arbitration in IDLE:
  - With a single requester, that port wins.
  - With both requesting, see Optional Feature.
- In OWNx:
  - Only port x can be granted.
  - The other port's gnt stays 0 even if it is requesting.
- Granted cycle:
  - gnt=1 for the winner only.
  - mem_read_en = req & ~we; mem_write_en = req & we.
  - mem_* selects track the winner.
- No grant: mem_read_en = mem_write_en = 0; mem_address, mem_write_data and mem_byte_enable = 0.
- Read latency:
  - A read granted in cycle N gives rvalid=1 for exactly cycle N+1 on the issuing port only.
  - rdata = mem_data_fetched during that cycle.
  - Writes produce no rvalid.
  - Back-to-back reads give back-to-back rvalid pulses.
- Transitions:
  - IDLE to OWNx when port x is granted with lock=1; lock counter = 1.
  - OWNx stays in OWNx while port x is granted with lock=1 and counter < MAX_LOCK; counter increments.
  - OWNx returns to IDLE when any of the following holds:
    - port x is granted with lock=0;
    - port x drops req;
    - counter reaches MAX_LOCK (forced release).
  - After a forced release, last_winner = x. The other port wins the next tie, in both arbitration modes.
- Cycle of release: the releasing access is still granted. Arbitration is open again on the following cycle.
- last_winner updates on every granted cycle.
- Requests:
  - Requests are level-sensitive.
  - A requester must hold req and all its inputs stable until it sees gnt.
  - The arbiter does not latch requests.
- Reset mid-operation: a pending rvalid is dropped and the lock is released. No memory enable is asserted during reset.

Optional Feature:
Macro DATA_ARB_ROUND_ROBIN_EN.
- Defined: when both ports request in IDLE, the port that is not last_winner wins (alternating).
- Undefined:
  - Port 0 has fixed priority on ties.
  - Exception: the cycle immediately after a forced MAX_LOCK release of port 0 goes to a requesting port 1, which prevents starvation.
  - last_winner is still maintained for that purpose.

Test Plan:
- Reset, then p0 read addr 0x0000_1000 with mem_data_fetched=0x1122334455667788 → p0_gnt=1 in cycle N; p0_rvalid=1 with that data in N+1; p1_rvalid=0 throughout.
- Both ports read, both held for 4 cycles, round-robin defined → grants ordered p0,p1,p0,p1. Without the macro → p0 granted all 4 cycles.
- p1 write 0xDEADBEEF to 0x0000_2008 with byte_enable=3'b010 → mem_write_en=1, mem_byte_enable=3'b010, mem_address=0x0000_2008; no rvalid on either port.
- p1 locked for 3 accesses while p0 requests → p0_gnt=0 for those 3 cycles. p1 then drops lock → p0 is granted the next cycle.
- p0 holds lock=1 and req=1 for 20 cycles with MAX_LOCK=15 → p0 granted 15 consecutive cycles; cycle 16 is granted to a requesting p1, with and without the macro.
- reset_n pulsed low the cycle after a granted read → p0_rvalid never asserts; state is IDLE; all outputs 0; the next access behaves as if after reset.
